// File: rtl/soc_test_pkg.sv
// Shared types and constants for the simulation/bring-up test controller.
package soc_test_pkg;

    // Controller lifecycle: hold core in reset, run, then one sticky terminal state.
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    // Magic address the test program stores its result to.
    localparam logic [63:0] DEFAULT_TOHOST_ADDR = 64'h0000_0000_8000_1000;

    // tohost value that means "all tests passed".
    localparam int unsigned PASS_CODE   = 32'd1;

    // Width of the failure code carried in wdata[32:1].
    localparam int unsigned FAIL_CODE_W = 32'd32;

    // A store terminates the test only when it hits tohost with the LSB set.
    function automatic logic is_term_write(input logic we, input logic addr_hit, input logic lsb);
        return we & addr_hit & lsb;
    endfunction

endpackage

// File: rtl/soc_trace_buf.sv
// Circular trace buffer: records probe vectors, reads back by age (0 = newest)
// with one cycle of latency and no write-to-read bypass.
module soc_trace_buf
    import soc_test_pkg::*;
#(
    parameter int W     = 15,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic [AW-1:0] rd_idx_s;

    // Next-state for storage, write pointer, fill count and age-indexed read.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rd_data_d = {W{1'b0}};
        // Age is measured from the entry before the current write pointer;
        // AW-bit arithmetic gives the modulo-DEPTH wrap for free.
        rd_idx_s  = wr_ptr_q - AW'(1) - rd_addr_i;

        if (wr_en_i) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // Reads use pre-write state, so a same-cycle write is not visible yet.
        if ({1'b0, rd_addr_i} >= count_q) begin
            rd_data_d = {W{1'b0}};
        end else begin
            rd_data_d = mem_q[rd_idx_s];
        end
    end

    // Trace state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            rd_data_q <= {W{1'b0}};
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

endmodule

// File: rtl/soc_test_ctrl.sv
// Bring-up controller: sequences core reset, decodes tohost pass/fail stores,
// runs a cycle watchdog and keeps a circular trace of debug probes.
module soc_test_ctrl
    import soc_test_pkg::*;
#(
    parameter int                XLEN           = 64,
    parameter int                RFIDX_W        = 5,
    parameter int                NUM_PROBES     = 3,
    parameter int                RST_CYCLES     = 4,
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                CNT_W          = 32,
    parameter int                TRACE_DEPTH    = 16,
    parameter logic [XLEN-1:0]   TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              core_rst_n,
    input  logic                              mon_we_i,
    input  logic [XLEN-1:0]                   mon_addr_i,
    input  logic [XLEN-1:0]                   mon_wdata_i,
    input  logic                              probe_valid_i,
    input  logic [NUM_PROBES*RFIDX_W-1:0]     probe_i,
    output logic                              done_o,
    output logic                              pass_o,
    output logic                              timeout_o,
    output logic [31:0]                       fail_code_o,
    output logic [CNT_W-1:0]                  cycle_cnt_o,
    output logic [$clog2(TRACE_DEPTH):0]      trace_count_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0]    trace_rd_addr_i,
    output logic [NUM_PROBES*RFIDX_W-1:0]     trace_rd_data_o
);

    localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]        cycle_cnt_q, cycle_cnt_d;
    logic                    core_rst_n_q, core_rst_n_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [FAIL_CODE_W-1:0]  fail_code_q, fail_code_d;
    logic                    term_s;
    logic                    pass_hit_s;
    logic                    trace_we_s;

    // tohost decode; only acted on while running.
    assign term_s     = is_term_write(mon_we_i, (mon_addr_i == TOHOST_ADDR), mon_wdata_i[0]);
    assign pass_hit_s = (mon_wdata_i == XLEN'(PASS_CODE));

    // FSM next-state, counters and sticky status; a terminating write beats the watchdog.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        core_rst_n_d = core_rst_n_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_code_d  = fail_code_q;
        trace_we_s   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                end else begin
                    state_d      = ST_HOLD;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                trace_we_s  = probe_valid_i;
                if (term_s) begin
                    done_d       = 1'b1;
                    core_rst_n_d = 1'b0;
                    if (pass_hit_s) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = mon_wdata_i[FAIL_CODE_W:1];
                    end
                end else if (cycle_cnt_q == TO_LAST) begin
                    state_d      = ST_TIMEOUT;
                    done_d       = 1'b1;
                    timeout_d    = 1'b1;
                    core_rst_n_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                // Terminal: everything frozen until rst_n.
                state_d = state_q;
            end
            default: begin
                state_d      = ST_HOLD;
                core_rst_n_d = 1'b0;
            end
        endcase
    end

    // Controller state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= {HOLD_W{1'b0}};
            cycle_cnt_q  <= {CNT_W{1'b0}};
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_code_q  <= {FAIL_CODE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_code_q  <= fail_code_d;
        end
    end

    soc_trace_buf #(
        .W     (NUM_PROBES * RFIDX_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (trace_we_s),
        .wr_data_i (probe_i),
        .rd_addr_i (trace_rd_addr_i),
        .rd_data_o (trace_rd_data_o),
        .count_o   (trace_count_o)
    );

    assign core_rst_n  = core_rst_n_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign fail_code_o = fail_code_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule
